soc_ram_ctrl: RTL and testbench

// - Parametrised on-chip instruction/data RAM with a soc_on control register, on the core/bus memory port.
// - Improvements over the fixed 4KB RAM: configurable region sizes, byte strobes, req/ready/rvalid

---
 rtl/soc_ram_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_soc_ram_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_ram_ctrl.sv
// On-chip IMEM/DMEM RAM with a soc_on control register behind a req/ready/rvalid memory port.
// Define SOC_RAM_OUT_REG_EN to add an output register stage, making the response latency 2 cycles.
module soc_ram_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 512,
  parameter logic [31:0] CTRL_ADDR  = 32'h0003_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  output logic [DATA_W-1:0]     soc_on_o,
  output logic                  init_done_o
);

  localparam int unsigned NB        = DATA_W / 8;
  localparam int unsigned IMEM_AW   = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DMEM_AW   = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int unsigned CLR_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
  localparam int unsigned CLR_AW    = (CLR_WORDS > 1) ? $clog2(CLR_WORDS) : 1;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [CLR_AW-1:0]   clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0]   soc_on_q, soc_on_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   imem [IMEM_WORDS];
  logic [DATA_W-1:0]   dmem [DMEM_WORDS];

  logic [29:0]         word;
  logic                hit_ctrl;
  logic                misaligned;
  logic                hit_imem;
  logic                hit_dmem;
  logic                accept;
  logic [IMEM_AW-1:0]  imem_idx;
  logic [DMEM_AW-1:0]  dmem_idx;

  logic                imem_we;
  logic                dmem_we;
  logic [IMEM_AW-1:0]  imem_waddr;
  logic [DMEM_AW-1:0]  dmem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_wbe;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  assign ready_o     = (state_q == ST_RUN);
  assign init_done_o = (state_q == ST_RUN);
  assign soc_on_o    = soc_on_q;
  assign accept      = req_i & ready_o & ~rst_i;

  // Address decode: CTRL wins over the alignment check, then IMEM, then DMEM.
  always_comb begin
    word       = addr_i[31:2];
    hit_ctrl   = (addr_i == CTRL_ADDR);
    misaligned = !hit_ctrl && (addr_i[1:0] != 2'b00);
    hit_imem   = !hit_ctrl && !misaligned && (32'(word) < IMEM_WORDS);
    hit_dmem   = !hit_ctrl && !misaligned && !hit_imem &&
                 (32'(word) < (IMEM_WORDS + DMEM_WORDS));
    imem_idx   = IMEM_AW'(word);
    dmem_idx   = DMEM_AW'(word - 30'(IMEM_WORDS));
  end

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    soc_on_d   = soc_on_q;
    rvalid_d   = 1'b0;
    rdata_d    = '0;
    err_d      = 1'b0;
    imem_we    = 1'b0;
    dmem_we    = 1'b0;
    imem_waddr = '0;
    dmem_waddr = '0;
    mem_wdata  = '0;
    mem_wbe    = '0;

    case (state_q)
      ST_CLEAR: begin
        // One index per cycle in both regions; the shorter region simply stops early.
        imem_we    = (32'(clr_idx_q) < IMEM_WORDS);
        dmem_we    = (32'(clr_idx_q) < DMEM_WORDS);
        imem_waddr = IMEM_AW'(clr_idx_q);
        dmem_waddr = DMEM_AW'(clr_idx_q);
        mem_wbe    = '1;
        if (clr_idx_q == CLR_AW'(CLR_WORDS - 1)) begin
          state_d = ST_RUN;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (accept) begin
          rvalid_d = 1'b1;
          if (hit_ctrl) begin
            if (we_i) soc_on_d = merge_bytes(soc_on_q, wdata_i, be_i);
            else      rdata_d  = soc_on_q;
          end else if (hit_imem) begin
            if (!we_i) begin
              rdata_d = imem[imem_idx];
            end else if (soc_on_q[0]) begin
              err_d = 1'b1;
            end else begin
              imem_we    = 1'b1;
              imem_waddr = imem_idx;
              mem_wdata  = wdata_i;
              mem_wbe    = be_i;
            end
          end else if (hit_dmem) begin
            if (!we_i) begin
              rdata_d = dmem[dmem_idx];
            end else begin
              dmem_we    = 1'b1;
              dmem_waddr = dmem_idx;
              mem_wdata  = wdata_i;
              mem_wbe    = be_i;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  // Storage arrays carry no reset; the CLEAR sequence zeroes them instead.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB; k++) begin
      if (imem_we && mem_wbe[k]) imem[imem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
      if (dmem_we && mem_wbe[k]) dmem[dmem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      soc_on_q  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      soc_on_q  <= soc_on_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

`ifdef SOC_RAM_OUT_REG_EN
  logic              out_rvalid_q, out_rvalid_d;
  logic [DATA_W-1:0] out_rdata_q, out_rdata_d;
  logic              out_err_q, out_err_d;

  always_comb begin
    out_rvalid_d = rvalid_q;
    out_rdata_d  = rdata_q;
    out_err_d    = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_rvalid_q <= 1'b0;
      out_rdata_q  <= '0;
      out_err_q    <= 1'b0;
    end else begin
      out_rvalid_q <= out_rvalid_d;
      out_rdata_q  <= out_rdata_d;
      out_err_q    <= out_err_d;
    end
  end

  assign rvalid_o = out_rvalid_q;
  assign rdata_o  = out_rdata_q;
  assign err_o    = out_err_q;
`else
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
`endif

endmodule

// File: tb/tb_soc_ram_ctrl.sv
// Self-checking bench for soc_ram_ctrl: flat-memory reference model checked every cycle,
// plus directed scenarios with literal expected responses.
`timescale 1ns/1ps
module tb_soc_ram_ctrl;

  localparam int unsigned IMEM_WORDS   = 512;
  localparam int unsigned DMEM_WORDS   = 512;
  localparam logic [31:0] CTRL_ADDR    = 32'h0003_0000;
  localparam int          CLEAR_CYCLES = 512;
`ifdef SOC_RAM_OUT_REG_EN
  localparam int          LAT = 2;
`else
  localparam int          LAT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] soc_on_o;
  logic        init_done_o;

  soc_ram_ctrl #(
    .DATA_W(32),
    .IMEM_WORDS(IMEM_WORDS),
    .DMEM_WORDS(DMEM_WORDS),
    .CTRL_ADDR(CTRL_ADDR)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .we_i(we_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .be_i(be_i),
    .ready_o(ready_o),
    .rvalid_o(rvalid_o),
    .rdata_o(rdata_o),
    .err_o(err_o),
    .soc_on_o(soc_on_o),
    .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_cyc = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one flat word array covering IMEM followed by DMEM.
  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        e;
  } resp_t;

  typedef struct {
    int          c;
    logic [31:0] d;
    logic        e;
  } obs_t;

  logic [31:0] mem_m [0:IMEM_WORDS+DMEM_WORDS-1];
  logic [31:0] soc_on_m;
  int          clr_cnt    = 0;
  bit          model_live = 1'b0;
  resp_t       pipe [LAT];
  obs_t        resp_q [$];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic resp_t serve(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be);
    resp_t       r;
    int unsigned w;
    r   = '0;
    r.v = 1'b1;
    w   = addr / 4;
    if (addr == CTRL_ADDR) begin
      if (we) soc_on_m = merge(soc_on_m, wdata, be);
      else    r.d = soc_on_m;
    end else if (addr % 4 != 0) begin
      r.e = 1'b1;
    end else if (w < IMEM_WORDS + DMEM_WORDS) begin
      if (!we)                                 r.d = mem_m[w];
      else if (w < IMEM_WORDS && soc_on_m[0])  r.e = 1'b1;
      else                                     mem_m[w] = merge(mem_m[w], wdata, be);
    end else begin
      r.e = 1'b1;
    end
    return r;
  endfunction

  // Model step on each rising edge, then compare all outputs just after it.
  always @(posedge clk_i) begin
    resp_t nr;
    cyc++;
    nr = '0;
    if (rst_i) begin
      for (int i = 0; i < IMEM_WORDS + DMEM_WORDS; i++) mem_m[i] = 32'h0;
      soc_on_m = 32'h0;
      clr_cnt  = 0;
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (req_i && clr_cnt >= CLEAR_CYCLES) nr = serve(we_i, addr_i, wdata_i, be_i);
      if (clr_cnt < CLEAR_CYCLES) clr_cnt++;
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = nr;
    end
    #1;
    if (model_live) begin
      check32("ready_o", 32'(ready_o), (clr_cnt >= CLEAR_CYCLES) ? 32'd1 : 32'd0);
      check32("init_done_o", 32'(init_done_o), (clr_cnt >= CLEAR_CYCLES) ? 32'd1 : 32'd0);
      check32("rvalid_o", 32'(rvalid_o), 32'(pipe[LAT-1].v));
      check32("rdata_o", rdata_o, pipe[LAT-1].d);
      check32("err_o", 32'(err_o), 32'(pipe[LAT-1].e));
      check32("soc_on_o", soc_on_o, soc_on_m);
      if (rvalid_o === 1'b1) resp_q.push_back('{cyc, rdata_o, err_o});
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    @(negedge clk_i);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
    be_i    = be;
  endtask

  task automatic idleBus(input int n);
    @(negedge clk_i);
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    be_i    = 4'h0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_d, input logic exp_e);
    int   waited;
    obs_t o;
    waited = 0;
    while (resp_q.size() == 0 && waited < 20) begin
      @(posedge clk_i);
      #2;
      waited++;
    end
    if (resp_q.size() == 0) begin
      checks++;
      failures++;
      last_cyc = -1;
      $display("[TB] FAIL %s: got no response expected rdata %h err %0d", name, exp_d, exp_e);
    end else begin
      o        = resp_q.pop_front();
      last_cyc = o.c;
      check32({name, "_rdata"}, o.d, exp_d);
      check32({name, "_err"}, 32'(o.e), 32'(exp_e));
    end
  endtask

  task automatic waitClear(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (ready_o !== 1'b1 && n < 2000);
    check32(name, 32'(n), 32'd512);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c1;
    rst_i   = 1'b1;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    be_i    = 4'h0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    waitClear("clear_cycles_boot");

    applyStimulus(1'b0, 32'h0000_0800, 32'h0, 4'h0);
    idleBus(3);
    checkOutput("boot_read_800", 32'h0, 1'b0);

    applyStimulus(1'b1, 32'h0000_0800, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1'b1, 32'h0000_0800, 32'h0000_5500, 4'b0010);
    applyStimulus(1'b0, 32'h0000_0800, 32'h0, 4'h0);
    idleBus(3);
    checkOutput("wr_full", 32'h0, 1'b0);
    checkOutput("wr_byte1", 32'h0, 1'b0);
    checkOutput("rd_merged", 32'hDEAD_55EF, 1'b0);

    applyStimulus(1'b1, 32'h0000_0804, 32'h1234_5678, 4'hF);
    applyStimulus(1'b0, 32'h0000_0804, 32'h0, 4'h0);
    idleBus(3);
    checkOutput("b2b_wr", 32'h0, 1'b0);
    c1 = last_cyc;
    checkOutput("b2b_rd", 32'h1234_5678, 1'b0);
    check32("b2b_spacing", 32'(last_cyc - c1), 32'd1);

    applyStimulus(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF);
    applyStimulus(1'b1, 32'h0000_0FFC, 32'h0000_0000, 4'h0);
    applyStimulus(1'b0, 32'h0000_0FFC, 32'h0, 4'h0);
    idleBus(3);
    checkOutput("dmem_last_wr", 32'h0, 1'b0);
    checkOutput("dmem_be0_wr", 32'h0, 1'b0);
    checkOutput("dmem_last_rd", 32'hCAFE_F00D, 1'b0);

    applyStimulus(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF);
    applyStimulus(1'b1, CTRL_ADDR, 32'h0000_0001, 4'hF);
    applyStimulus(1'b1, 32'h0000_0010, 32'h0000_0000, 4'hF);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    applyStimulus(1'b0, CTRL_ADDR, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h0000_0808, 32'h0BAD_F00D, 4'hF);
    applyStimulus(1'b0, 32'h0000_0808, 32'h0, 4'h0);
    idleBus(3);
    checkOutput("imem_wr_unlocked", 32'h0, 1'b0);
    checkOutput("ctrl_wr", 32'h0, 1'b0);
    checkOutput("imem_wr_locked", 32'h0, 1'b1);
    checkOutput("imem_rd_locked", 32'hA5A5_A5A5, 1'b0);
    checkOutput("ctrl_rd", 32'h0000_0001, 1'b0);
    checkOutput("dmem_wr_locked", 32'h0, 1'b0);
    checkOutput("dmem_rd_locked", 32'h0BAD_F00D, 1'b0);
    check32("soc_on_set", soc_on_o, 32'h0000_0001);

    applyStimulus(1'b0, 32'h0000_1002, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    applyStimulus(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1'b1, 32'h0000_0802, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1'b0, 32'h0000_0800, 32'h0, 4'h0);
    idleBus(3);
    checkOutput("err_misaligned_rd", 32'h0, 1'b1);
    checkOutput("err_unmapped_rd", 32'h0, 1'b1);
    checkOutput("err_unmapped_wr", 32'h0, 1'b1);
    checkOutput("err_misaligned_wr", 32'h0, 1'b1);
    checkOutput("rd_after_errors", 32'hDEAD_55EF, 1'b0);

    @(negedge clk_i);
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 32'h0000_0800;
    rst_i  = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    waitClear("clear_cycles_rerun");
    check32("no_resp_after_reset", 32'(resp_q.size()), 32'd0);
    check32("soc_on_after_reset", soc_on_o, 32'h0);

    applyStimulus(1'b0, 32'h0000_0800, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 4'h0);
    idleBus(3);
    checkOutput("rd_800_after_reset", 32'h0, 1'b0);
    checkOutput("rd_010_after_reset", 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
